// File: rtl/ysyx_22050854_axi_pkg.sv
// Shared AXI4 encodings, FSM state types and transaction-level helpers
// for the burst SRAM slave.
package ysyx_22050854_axi_pkg;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;
   localparam logic [1:0] BURST_RSVD  = 2'b11;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
   typedef enum logic [1:0] {W_IDLE, W_WAIT, W_DATA, W_RESP} w_state_t;

   function automatic logic [7:0] beat_bytes(input logic [2:0] size);
      return 8'd1 << size;
   endfunction

   function automatic logic wrap_len_ok(input logic [7:0] len);
      return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
   endfunction

   // Transaction-wide SLVERR: reserved burst, illegal wrap length, or beat wider than the bus.
   function automatic logic txn_slverr(input logic [1:0] burst, input logic [7:0] len,
                                       input logic [2:0] size, input int unsigned bus_bytes);
      return (burst == BURST_RSVD) ||
             ((burst == BURST_WRAP) && !wrap_len_ok(len)) ||
             (32'(beat_bytes(size)) > bus_bytes);
   endfunction

endpackage

// File: rtl/ysyx_22050854_axi_burst_addr.sv
// Combinational next-beat address generator for FIXED/INCR/WRAP bursts.
// Illegal wrap lengths and the reserved burst type step like INCR.
module ysyx_22050854_axi_burst_addr #(
   parameter int ADDR_W = 32
) (
   input  logic [ADDR_W-1:0] addr,
   input  logic [2:0]        size,
   input  logic [7:0]        len,
   input  logic [1:0]        burst,
   output logic [ADDR_W-1:0] next_addr
);
   import ysyx_22050854_axi_pkg::*;

   logic [ADDR_W-1:0] step;
   logic [ADDR_W-1:0] span;
   logic [ADDR_W-1:0] incr;
   logic [ADDR_W-1:0] wrapped;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      step      = ADDR_W'(beat_bytes(size));
      span      = (ADDR_W'(len) + ADDR_W'(1)) << size;
      incr      = addr + step;
      wrapped   = (addr & ~(span - ADDR_W'(1))) | (incr & (span - ADDR_W'(1)));
      next_addr = incr;
      if (burst == BURST_FIXED) begin
         next_addr = addr;
      end else if ((burst == BURST_WRAP) && wrap_len_ok(len)) begin
         next_addr = wrapped;
      end
   end

endmodule

// File: rtl/ysyx_22050854_axi_burst_sram.sv
// AXI4 burst SRAM slave with independent read and write FSMs, one
// outstanding transaction per direction, configurable latencies and error responses.
module ysyx_22050854_axi_burst_sram #(
   parameter int                 DATA_W    = 64,
   parameter int                 ADDR_W    = 32,
   parameter int                 ID_W      = 4,
   parameter int                 DEPTH     = 16384,
   parameter logic [ADDR_W-1:0]  BASE_ADDR = 'h8000_0000,
   parameter int                 READ_LAT  = 2,
   parameter int                 WRITE_LAT = 1
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                awvalid,
   output logic                awready,
   input  logic [ID_W-1:0]     awid,
   input  logic [ADDR_W-1:0]   awaddr,
   input  logic [7:0]          awlen,
   input  logic [2:0]          awsize,
   input  logic [1:0]          awburst,
   input  logic                wvalid,
   output logic                wready,
   input  logic [DATA_W-1:0]   wdata,
   input  logic [DATA_W/8-1:0] wstrb,
   input  logic                wlast,
   output logic                bvalid,
   input  logic                bready,
   output logic [ID_W-1:0]     bid,
   output logic [1:0]          bresp,
   input  logic                arvalid,
   output logic                arready,
   input  logic [ID_W-1:0]     arid,
   input  logic [ADDR_W-1:0]   araddr,
   input  logic [7:0]          arlen,
   input  logic [2:0]          arsize,
   input  logic [1:0]          arburst,
   output logic                rvalid,
   input  logic                rready,
   output logic [ID_W-1:0]     rid,
   output logic [DATA_W-1:0]   rdata,
   output logic [1:0]          rresp,
   output logic                rlast
);
   import ysyx_22050854_axi_pkg::*;

   localparam int                BYTES     = DATA_W / 8;
   localparam int                OFF_W     = $clog2(BYTES);
   localparam int                IDX_W     = $clog2(DEPTH);
   localparam logic [ADDR_W-1:0] MEM_BYTES = ADDR_W'(DEPTH * BYTES);

   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      return (a >= BASE_ADDR) && ((a - BASE_ADDR) < MEM_BYTES);
   endfunction

   function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
      return IDX_W'((a - BASE_ADDR) >> OFF_W);
   endfunction

   logic [DATA_W-1:0] mem [DEPTH];

   // ---------------- read channel ----------------
   r_state_t          r_state, r_next;
   logic [ADDR_W-1:0] r_addr, r_next_addr, r_load_addr;
   logic [7:0]        r_len, r_beat;
   logic [2:0]        r_size;
   logic [1:0]        r_burst;
   logic              r_slverr, r_load, r_load_first, r_load_last, r_load_err;
   logic [3:0]        r_lat;
   logic [ID_W-1:0]   rid_q;
   logic [DATA_W-1:0] rdata_q;
   logic [1:0]        rresp_q;
   logic              rlast_q;
   logic              ar_hs, r_hs;

   ysyx_22050854_axi_burst_addr #(.ADDR_W(ADDR_W)) u_raddr (
      .addr(r_addr), .size(r_size), .len(r_len), .burst(r_burst), .next_addr(r_next_addr)
   );

   assign arready = (r_state == R_IDLE) & ~reset;
   assign rvalid  = (r_state == R_DATA) & ~reset;
   assign rlast   = rlast_q & rvalid;
   assign rid     = rid_q;
   assign rdata   = rdata_q;
   assign rresp   = rresp_q;
   assign ar_hs   = arvalid & arready;
   assign r_hs    = rvalid & rready;

   // r_load registers the next beat; the address comes from the AR bus, the latched start, or the stepped address.
   always_comb begin
      r_next       = r_state;
      r_load       = 1'b0;
      r_load_first = 1'b0;
      r_load_addr  = r_next_addr;
      r_load_err   = r_slverr;
      r_load_last  = (r_beat + 8'd1 == r_len);
      case (r_state)
         R_IDLE: if (ar_hs) begin
            if (READ_LAT == 0) begin
               r_next       = R_DATA;
               r_load       = 1'b1;
               r_load_first = 1'b1;
               r_load_addr  = araddr;
               r_load_err   = txn_slverr(arburst, arlen, arsize, BYTES);
               r_load_last  = (arlen == 8'd0);
            end else begin
               r_next = R_WAIT;
            end
         end
         R_WAIT: if (r_lat == 4'(READ_LAT - 1)) begin
            r_next       = R_DATA;
            r_load       = 1'b1;
            r_load_first = 1'b1;
            r_load_addr  = r_addr;
            r_load_last  = (r_len == 8'd0);
         end
         R_DATA: if (r_hs) begin
            if (rlast_q) r_next = R_IDLE;
            else         r_load = 1'b1;
         end
         default: r_next = R_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state  <= R_IDLE;
         r_addr   <= '0;
         r_len    <= '0;
         r_size   <= '0;
         r_burst  <= '0;
         r_slverr <= 1'b0;
         r_beat   <= '0;
         r_lat    <= '0;
         rid_q    <= '0;
         rdata_q  <= '0;
         rresp_q  <= RESP_OKAY;
         rlast_q  <= 1'b0;
      end else begin
         r_state <= r_next;
         if (ar_hs) begin
            rid_q    <= arid;
            r_addr   <= araddr;
            r_len    <= arlen;
            r_size   <= arsize;
            r_burst  <= arburst;
            r_slverr <= txn_slverr(arburst, arlen, arsize, BYTES);
            r_lat    <= '0;
         end else if (r_state == R_WAIT) begin
            r_lat <= r_lat + 4'd1;
         end
         if (r_load) begin
            r_addr  <= r_load_addr;
            r_beat  <= r_load_first ? 8'd0 : r_beat + 8'd1;
            rlast_q <= r_load_last;
            if (in_range(r_load_addr)) begin
               rdata_q <= mem[word_idx(r_load_addr)];
               rresp_q <= r_load_err ? RESP_SLVERR : RESP_OKAY;
            end else begin
               rdata_q <= '0;
               rresp_q <= RESP_DECERR;
            end
         end
      end
   end

   // ---------------- write channel ----------------
   w_state_t          w_state, w_next;
   logic [ADDR_W-1:0] w_addr, w_next_addr;
   logic [7:0]        w_len, w_beat;
   logic [2:0]        w_size;
   logic [1:0]        w_burst;
   logic              w_slverr, w_beat_last, w_in_range, w_we;
   logic [3:0]        w_lat;
   logic [ID_W-1:0]   bid_q;
   logic [1:0]        bresp_q, w_beat_resp;
   logic              aw_hs, w_hs;

   ysyx_22050854_axi_burst_addr #(.ADDR_W(ADDR_W)) u_waddr (
      .addr(w_addr), .size(w_size), .len(w_len), .burst(w_burst), .next_addr(w_next_addr)
   );

   assign awready     = (w_state == W_IDLE) & ~reset;
   assign wready      = (w_state == W_DATA) & ~reset;
   assign bvalid      = (w_state == W_RESP) & ~reset;
   assign bid         = bid_q;
   assign bresp       = bresp_q;
   assign aw_hs       = awvalid & awready;
   assign w_hs        = wvalid & wready;
   assign w_beat_last = (w_beat == w_len);
   assign w_in_range  = in_range(w_addr);
   assign w_we        = w_hs & w_in_range & ~w_slverr;

   // The beat count, not wlast, ends the burst; a wlast mismatch only taints the response.
   always_comb begin
      w_next      = w_state;
      w_beat_resp = RESP_OKAY;
      if (!w_in_range)                             w_beat_resp = RESP_DECERR;
      else if (w_slverr || (wlast != w_beat_last)) w_beat_resp = RESP_SLVERR;
      case (w_state)
         W_IDLE: if (aw_hs) w_next = (WRITE_LAT == 0) ? W_DATA : W_WAIT;
         W_WAIT: if (w_lat == 4'(WRITE_LAT - 1)) w_next = W_DATA;
         W_DATA: if (w_hs && w_beat_last) w_next = W_RESP;
         W_RESP: if (bready) w_next = W_IDLE;
         default: w_next = W_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         w_state  <= W_IDLE;
         w_addr   <= '0;
         w_len    <= '0;
         w_size   <= '0;
         w_burst  <= '0;
         w_slverr <= 1'b0;
         w_beat   <= '0;
         w_lat    <= '0;
         bid_q    <= '0;
         bresp_q  <= RESP_OKAY;
      end else begin
         w_state <= w_next;
         if (aw_hs) begin
            bid_q    <= awid;
            w_addr   <= awaddr;
            w_len    <= awlen;
            w_size   <= awsize;
            w_burst  <= awburst;
            w_slverr <= txn_slverr(awburst, awlen, awsize, BYTES);
            w_beat   <= '0;
            w_lat    <= '0;
            bresp_q  <= RESP_OKAY;
         end else if (w_state == W_WAIT) begin
            w_lat <= w_lat + 4'd1;
         end
         if (w_hs) begin
            w_addr <= w_next_addr;
            w_beat <= w_beat + 8'd1;
            if (w_beat_resp > bresp_q) bresp_q <= w_beat_resp;
         end
      end
   end

   // NOTE: the memory array has no reset; contents survive reset and map onto plain RAM.
   always_ff @(posedge clock) begin
      if (w_we) begin
         for (int b = 0; b < BYTES; b++) begin
            if (wstrb[b]) mem[word_idx(w_addr)][b*8 +: 8] <= wdata[b*8 +: 8];
         end
      end
   end

endmodule

// File: tb/tb_ysyx_22050854_axi_burst_sram.sv
// Randomised self-checking bench for the AXI burst SRAM against a
// transaction-level memory model built from the AXI burst rules.
module tb_ysyx_22050854_axi_burst_sram;

   localparam int          READ_LAT  = 2;
   localparam int          WRITE_LAT = 1;
   localparam int          DEPTH     = 16384;
   localparam logic [31:0] BASE      = 32'h8000_0000;
   localparam int          LIMIT     = 200;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        awvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0, bready = 1'b0;
   logic        arvalid = 1'b0, rready = 1'b0;
   logic [3:0]  awid = '0, arid = '0;
   logic [31:0] awaddr = '0, araddr = '0;
   logic [7:0]  awlen = '0, arlen = '0, wstrb = '0;
   logic [2:0]  awsize = '0, arsize = '0;
   logic [1:0]  awburst = '0, arburst = '0;
   logic [63:0] wdata = '0;
   logic        awready, wready, bvalid, arready, rvalid, rlast;
   logic [3:0]  bid, rid;
   logic [1:0]  bresp, rresp;
   logic [63:0] rdata;

   int errors = 0;
   int checks = 0;
   logic [63:0] mdl [int];

   always #5 clock = ~clock;

   ysyx_22050854_axi_burst_sram #(
      .DATA_W(64), .ADDR_W(32), .ID_W(4), .DEPTH(DEPTH), .BASE_ADDR(BASE),
      .READ_LAT(READ_LAT), .WRITE_LAT(WRITE_LAT)
   ) dut (
      .clock(clock), .reset(reset),
      .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr),
      .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
      .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
      .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr),
      .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // ---- reference model: AXI burst rules in plain arithmetic ----
   function automatic logic [31:0] beat_addr(input logic [31:0] start, input int len,
                                             input int size, input int burst, input int i);
      logic [31:0] nb, span, lower;
      nb = 32'd1 << size;
      if (burst == 0) return start;
      if (burst == 2 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
         span  = nb * 32'(len + 1);
         lower = start - (start % span);
         return lower + ((start - lower) + nb * 32'(i)) % span;
      end
      return start + nb * 32'(i);
   endfunction

   function automatic logic txn_err(input int burst, input int len, input int size);
      return (burst == 3) ||
             (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15)) ||
             ((1 << size) > 8);
   endfunction

   function automatic logic in_rng(input logic [31:0] a);
      return (a >= BASE) && (a < BASE + 32'(DEPTH * 8));
   endfunction

   function automatic int widx(input logic [31:0] a);
      return int'((a - BASE) >> 3);
   endfunction

   task automatic axi_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [3:0] id,
                            input logic rand_data, input logic [63:0] fdata,
                            input logic rand_strb, input logic [7:0] fstrb, input logic bad_last);
      int          guard;
      logic        terr;
      logic [1:0]  exp_resp;
      logic [31:0] a;
      logic [63:0] d;
      logic [7:0]  s;
      int          idx;
      terr     = txn_err(int'(burst), int'(len), int'(size));
      exp_resp = 2'd0;
      @(negedge clock);
      awvalid = 1'b1; awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst;
      guard = 0;
      while (!awready && guard < LIMIT) begin @(negedge clock); guard++; end
      if (!awready) begin check("aw_timeout", 64'(awready), 64'd1); awvalid = 1'b0; return; end
      @(negedge clock);
      awvalid = 1'b0;
      wvalid  = 1'b1;
      for (int i = 0; i <= int'(len); i++) begin
         d = rand_data ? {$urandom, $urandom} : fdata;
         s = rand_strb ? 8'($urandom_range(0, 255)) : fstrb;
         wdata = d; wstrb = s;
         wlast = (i == int'(len)) ^ (bad_last && i == 0);
         guard = 0;
         while (!wready && guard < LIMIT) begin @(negedge clock); guard++; end
         if (i == 0) check("w_first_lat", 64'(guard), 64'(WRITE_LAT));
         if (!wready) begin check("w_timeout", 64'(wready), 64'd1); wvalid = 1'b0; return; end
         a = beat_addr(addr, int'(len), int'(size), int'(burst), i);
         if (!in_rng(a)) begin
            exp_resp = 2'd3;
         end else begin
            if ((terr || (wlast != (i == int'(len)))) && exp_resp < 2'd2) exp_resp = 2'd2;
            if (!terr) begin
               idx = widx(a);
               if (mdl.exists(idx)) begin
                  for (int b = 0; b < 8; b++) if (s[b]) mdl[idx][b*8 +: 8] = d[b*8 +: 8];
               end else if (s == 8'hFF) begin
                  mdl[idx] = d;
               end
            end
         end
         @(negedge clock);
      end
      wvalid = 1'b0; wlast = 1'b0;
      check("w_ready_done", 64'(wready), 64'd0);
      repeat ($urandom_range(0, 2)) begin
         check("b_valid_hold", 64'(bvalid), 64'd1);
         @(negedge clock);
      end
      check("b_valid", 64'(bvalid), 64'd1);
      check("b_resp", 64'(bresp), 64'(exp_resp));
      check("b_id", 64'(bid), 64'(id));
      bready = 1'b1;
      @(negedge clock);
      bready = 1'b0;
      check("b_valid_clear", 64'(bvalid), 64'd0);
      check("aw_ready_after_b", 64'(awready), 64'd1);
   endtask

   // rmode: 0 rready always high, 1 toggling, 2 random
   task automatic axi_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [3:0] id, input int rmode);
      int          guard, lat, k, idx;
      logic        terr, known;
      logic [31:0] a;
      logic [1:0]  er;
      logic [63:0] ed;
      terr = txn_err(int'(burst), int'(len), int'(size));
      @(negedge clock);
      arvalid = 1'b1; arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
      guard = 0;
      while (!arready && guard < LIMIT) begin @(negedge clock); guard++; end
      if (!arready) begin check("ar_timeout", 64'(arready), 64'd1); arvalid = 1'b0; return; end
      lat = 0;
      do begin
         @(negedge clock);
         arvalid = 1'b0;
         lat++;
      end while (!rvalid && lat < LIMIT);
      check("r_first_lat", 64'(lat), 64'(1 + READ_LAT));
      k = 0; guard = 0;
      while (k <= int'(len) && guard < LIMIT * 4) begin
         guard++;
         check("r_valid", 64'(rvalid), 64'd1);
         if (!rvalid) break;
         a = beat_addr(addr, int'(len), int'(size), int'(burst), k);
         if (!in_rng(a)) begin
            er = 2'd3; ed = '0; known = 1'b1;
         end else begin
            er    = terr ? 2'd2 : 2'd0;
            idx   = widx(a);
            known = !terr && mdl.exists(idx);
            ed    = known ? mdl[idx] : '0;
         end
         check("r_resp", 64'(rresp), 64'(er));
         check("r_last", 64'(rlast), 64'(k == int'(len)));
         check("r_id", 64'(rid), 64'(id));
         if (known) check("r_data", rdata, ed);
         case (rmode)
            0:       rready = 1'b1;
            1:       rready = (k == 0 && !rready) ? 1'b1 : ~rready;
            default: rready = 1'($urandom_range(0, 1));
         endcase
         if (rready) k++;
         @(negedge clock);
      end
      rready = 1'b0;
      check("r_beats", 64'(k), 64'(int'(len) + 1));
      check("r_valid_done", 64'(rvalid), 64'd0);
      check("ar_ready_after_r", 64'(arready), 64'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "simulation did not finish");
   end

   initial begin
      logic [63:0] d0, d1;
      logic [1:0]  bu;
      logic [2:0]  sz;
      logic [7:0]  ln;
      logic [31:0] ad;
      int          word;

      // reset state
      repeat (3) @(negedge clock);
      check("rst_arready", 64'(arready), 64'd0);
      check("rst_awready", 64'(awready), 64'd0);
      check("rst_wready",  64'(wready),  64'd0);
      check("rst_rvalid",  64'(rvalid),  64'd0);
      check("rst_bvalid",  64'(bvalid),  64'd0);
      check("rst_rlast",   64'(rlast),   64'd0);
      check("rst_rdata",   rdata,        64'd0);
      check("rst_ids",     64'({rid, bid}), 64'd0);
      check("rst_resps",   64'({rresp, bresp}), 64'd0);
      reset = 1'b0;
      @(negedge clock);
      check("idle_arready", 64'(arready), 64'd1);
      check("idle_awready", 64'(awready), 64'd1);

      // fill words 0..127 with known data
      axi_write(BASE, 8'd127, 3'd3, 2'd1, 4'd1, 1'b1, '0, 1'b0, 8'hFF, 1'b0);

      // INCR read of words 2..5
      axi_read(32'h8000_0010, 8'd3, 3'd3, 2'd1, 4'd2, 0);

      // WRAP write 6,7,4,5 then read back 4..7
      axi_write(32'h8000_0030, 8'd3, 3'd3, 2'd2, 4'd3, 1'b1, '0, 1'b0, 8'hFF, 1'b0);
      axi_read(32'h8000_0020, 8'd3, 3'd3, 2'd1, 4'd4, 0);

      // strobed narrow write over an all-ones word
      axi_write(32'h8000_0050, 8'd0, 3'd3, 2'd1, 4'd5, 1'b0, '1, 1'b0, 8'hFF, 1'b0);
      axi_write(32'h8000_0050, 8'd0, 3'd2, 2'd1, 4'd5, 1'b1, '0, 1'b0, 8'h0F, 1'b0);
      check("narrow_model_upper", 64'(mdl[10][63:32]), 64'hFFFF_FFFF);
      axi_read(32'h8000_0050, 8'd0, 3'd3, 2'd1, 4'd6, 0);

      // decode error below base, and illegal wrap length
      axi_read(32'h7FFF_FFF8, 8'd1, 3'd3, 2'd0, 4'd7, 0);
      axi_read(32'h8000_0040, 8'd2, 3'd3, 2'd2, 4'd8, 0);

      // write straddling the base: beat 0 DECERR, beat 1 lands in word 0
      axi_write(32'h7FFF_FFF8, 8'd1, 3'd3, 2'd1, 4'd9, 1'b1, '0, 1'b0, 8'hFF, 1'b0);
      axi_read(BASE, 8'd0, 3'd3, 2'd1, 4'd9, 0);

      // wlast mismatch: SLVERR but data written
      axi_write(32'h8000_0060, 8'd1, 3'd3, 2'd1, 4'd10, 1'b1, '0, 1'b0, 8'hFF, 1'b1);
      axi_read(32'h8000_0060, 8'd1, 3'd3, 2'd1, 4'd10, 0);

      // stalled 8-beat read concurrent with an independent write burst
      fork
         axi_read(BASE, 8'd7, 3'd3, 2'd1, 4'd11, 1);
         axi_write(32'h8000_0100, 8'd7, 3'd3, 2'd1, 4'd12, 1'b1, '0, 1'b1, 8'h00, 1'b0);
      join
      axi_read(32'h8000_0100, 8'd7, 3'd3, 2'd1, 4'd12, 2);

      // reset during beat 2 of a 4-beat write to words 64..67
      d0 = {$urandom, $urandom};
      d1 = {$urandom, $urandom};
      @(negedge clock);
      awvalid = 1'b1; awid = 4'd13; awaddr = 32'h8000_0200; awlen = 8'd3; awsize = 3'd3; awburst = 2'd1;
      @(negedge clock);
      awvalid = 1'b0;
      wvalid = 1'b1; wdata = d0; wstrb = 8'hFF; wlast = 1'b0;
      begin
         int g;
         g = 0;
         while (!wready && g < LIMIT) begin @(negedge clock); g++; end
      end
      check("rst_mid_wready", 64'(wready), 64'd1);
      @(negedge clock);
      mdl[64] = d0;
      wdata = d1;
      reset = 1'b1;
      @(negedge clock);
      check("rst_mid_wready_low",  64'(wready),  64'd0);
      check("rst_mid_bvalid_low",  64'(bvalid),  64'd0);
      check("rst_mid_awready_low", 64'(awready), 64'd0);
      check("rst_mid_arready_low", 64'(arready), 64'd0);
      check("rst_mid_rvalid_low",  64'(rvalid),  64'd0);
      wvalid = 1'b0;
      reset  = 1'b0;
      @(negedge clock);
      check("rst_mid_awready_back", 64'(awready), 64'd1);
      check("rst_mid_bvalid_idle",  64'(bvalid),  64'd0);
      axi_read(32'h8000_0200, 8'd1, 3'd3, 2'd1, 4'd14, 0);
      axi_write(32'h8000_0200, 8'd3, 3'd3, 2'd1, 4'd15, 1'b1, '0, 1'b0, 8'hFF, 1'b0);

      // randomised mix of reads and writes inside the initialised region
      for (int t = 0; t < 24; t++) begin
         bu = 2'($urandom_range(0, 2));
         sz = 3'($urandom_range(0, 3));
         case ($urandom_range(0, 5))
            0:       ln = 8'd0;
            1:       ln = 8'd1;
            2:       ln = 8'd3;
            3:       ln = 8'd7;
            4:       ln = 8'd15;
            default: ln = 8'($urandom_range(0, 15));
         endcase
         word = int'($urandom_range(0, 100));
         ad   = BASE + 32'(word * 8) + (32'($urandom_range(0, 7)) & ~((32'd1 << sz) - 32'd1));
         if ($urandom_range(0, 1) == 1)
            axi_write(ad, ln, sz, bu, 4'($urandom_range(0, 15)), 1'b1, '0, 1'b1, 8'h00, 1'b0);
         else
            axi_read(ad, ln, sz, bu, 4'($urandom_range(0, 15)), 2);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ysyx_22050854_axi_burst_sram.md
# ysyx_22050854_axi_burst_sram

Parametrised AXI4 burst memory slave: the next-generation simulation/FPGA memory behind the CPU `io_master` port, replacing the fixed 64-bit single-mode memory model. Supports FIXED/INCR/WRAP bursts, narrow transfers, byte strobes, configurable read/write latency and error responses for decode/protocol faults. Read and write channels run independently and concurrently, with one outstanding transaction per direction.

## Interface
- DATA_W, 64, data bus width in bits (32/64/128)
- ADDR_W, 32, address width
- ID_W, 4, AXI ID width
- DEPTH, 16384, memory depth in DATA_W words (power of two)
- BASE_ADDR, 32'h8000_0000, byte address of word 0
- READ_LAT, 2, idle cycles between AR handshake and first R beat (0..15)
- WRITE_LAT, 1, idle cycles between AW handshake and first wready (0..15)
- clock  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- awvalid/awready  in/out  1  write address handshake
- awid  in  ID_W;  awaddr  in  ADDR_W;  awlen  in  8;  awsize  in  3;  awburst  in  2
- wvalid/wready  in/out  1;  wdata  in  DATA_W;  wstrb  in  DATA_W/8;  wlast  in  1
- bvalid/bready  out/in  1;  bid  out  ID_W;  bresp  out  2
- arvalid/arready  in/out  1;  arid  in  ID_W;  araddr  in  ADDR_W;  arlen  in  8;  arsize  in  3;  arburst  in  2
- rvalid/rready  out/in  1;  rid  out  ID_W;  rdata  out  DATA_W;  rresp  out  2;  rlast  out  1

## Operation
- Read FSM: R_IDLE -> (AR handshake) R_WAIT -> (latency counter hits READ_LAT) R_DATA -> (last beat handshake) R_IDLE. READ_LAT=0 goes R_IDLE -> R_DATA directly.
- Write FSM: W_IDLE -> (AW handshake) W_WAIT -> W_DATA -> (awlen+1 beats accepted) W_RESP -> (B handshake) W_IDLE. WRITE_LAT=0 skips W_WAIT.
- arready = R_IDLE & ~reset; awready = W_IDLE & ~reset. ID, len, size, burst latched at address handshake.
- Beat address: FIXED keeps start; INCR adds 2^size; WRAP wraps on boundary (awlen+1)*2^size, aligned down. Word index = (addr - BASE_ADDR) >> log2(DATA_W/8), modulo-free.
- rdata returns the full addressed word (no lane shifting); writes update only bytes with wstrb=1.
- Error rules (per transaction, checked at address handshake): burst=3, WRAP with len not in {1,3,7,15}, or 2^size > DATA_W/8 -> SLVERR (2). Per beat: address outside [BASE_ADDR, BASE_ADDR+DEPTH*DATA_W/8) -> DECERR (3), rdata=0, write dropped. Otherwise OKAY (0).
- Write beat count governs termination: exactly awlen+1 beats accepted; wlast mismatch on any beat sets SLVERR but beats still written if otherwise legal. bresp = highest-priority error seen (DECERR > SLVERR > OKAY).
- Same-word read and write in one cycle: R beat registered that cycle returns old contents.

## Timing
- Reset: all FSMs idle; arready, awready, wready, rvalid, rlast, bvalid = 0 while reset high; rid, bid, rresp, bresp, rdata = 0. Memory contents not cleared.
- AR handshake at cycle T -> first rvalid at T+1+READ_LAT; beats back-to-back while rready=1; rvalid/rdata/rlast stable until rready. arready returns 1 the cycle after the last R handshake.
- AW handshake at T -> wready high from T+1+WRITE_LAT through last beat; bvalid the cycle after last W handshake, held until bready; awready 1 the cycle after B handshake.
- W data presented before wready is not consumed. Reset mid-burst aborts immediately; no partial B/R beat issued after reset.

## Structure
- Package ysyx_22050854_axi_pkg: BURST_FIXED/INCR/WRAP, RESP_OKAY/EXOKAY/SLVERR/DECERR, beat-size helper.
- Sub-module ysyx_22050854_axi_burst_addr: combinational next-beat address (addr, size, len, burst) shared by both FSMs.

## Test plan
- INCR read, araddr=0x8000_0010, arlen=3, size=3, READ_LAT=2, rready=1 -> first rvalid at T+3, 4 beats words 2..5, rlast on beat 4, rresp=0.
- WRAP write, awaddr=0x8000_0030, len=3, size=3 -> words written 6,7,4,5; bresp=0; read-back matches.
- Strobed narrow write wstrb=8'h0F, size=2 over 0xFFFF_FFFF word -> upper 4 bytes unchanged, lower replaced.
- Read at 0x7FFF_FFF8 arlen=1 -> both beats DECERR, rdata=0; WRAP len=2 -> SLVERR, 3 beats still returned.
- rready toggled 1/0 each cycle during 8-beat read -> no beat lost/duplicated, data stable while stalled; concurrent write burst completes independently.
- Reset asserted during beat 2 of 4-beat write -> next cycle all valids/readies 0; new AW accepted after reset release.
